alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single-cycle combinational ALU between two requesters: the integer pipeline (requester 0) and the crypto coprocessor (requester 1). It is a round-robin arbiter with per-requester valid/ready request and response channels and one registered response slot per requester. A bounded lock mechanism keeps multi-op crypto sequences (e.g. ROTL then XOR then ADD) on the ALU back-to-back. The block drives the ALU operand and control inputs and captures the ALU result.

## Interface
- DATA_W, 32, operand/result width
- CTRL_W, 4, ALU control code width
- LOCK_MAX, 8, maximum cycles a lock may be held (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  request valid (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle (combinational)
- reqN_ctrl  in  CTRL_W  ALU control code
- reqN_a, reqN_b  in  DATA_W  operands
- reqN_lock  in  1  keep grant for this requester after this request
- rspN_valid  out  1  response slot N full
- rspN_ready  in  1  consumer takes response N
- rspN_result  out  DATA_W  captured ALU Result
- rspN_zero  out  1  captured ALU Zero
- alu_a, alu_b  out  DATA_W  ALU operands (combinational)
- alu_ctrl  out  CTRL_W  ALU control (combinational)
- alu_result  in  DATA_W  ALU Result
- alu_zero  in  1  ALU Zero
- lock_owner  out  2  bit N set while requester N holds the lock (one-hot or zero)

## Operation
- slot_freeN = !rspN_valid | rspN_ready.
- eligN = reqN_valid & slot_freeN.
- At most one grant per cycle. reqN_ready = grantN.
- FSM states are UNLOCKED, LOCKED0 and LOCKED1. Reset state is UNLOCKED.
- UNLOCKED: if only one requester is eligible, grant it. If both are eligible, grant the requester indicated by rr_ptr (reset 0).
- UNLOCKED, on a grant to N with reqN_lock=0: rr_ptr <= ~N.
- UNLOCKED, on a grant to N with reqN_lock=1: go to LOCKEDN, lock_cnt <= 0.
- LOCKEDN: only requester N can be granted; the other requester's ready is held 0.
- LOCKEDN: lock_cnt increments every cycle, whether or not a grant occurs.
- LOCKEDN exits to UNLOCKED with rr_ptr <= ~N on either of two events:
  - a grant to N with reqN_lock=0;
  - lock_cnt == LOCK_MAX-1. This is a forced release. It takes priority even if the same-cycle grant has lock=1; that grant is still accepted.
- A grant drives alu_a/alu_b/alu_ctrl from the granted request.
- With no grant, alu_a=0, alu_b=0, alu_ctrl=4'b0000.
- On a grant to N, the following are loaded at the clock edge: rspN_result <= alu_result, rspN_zero <= alu_zero, rspN_valid <= 1.
- Without a grant to N: rspN_valid clears when rspN_ready=1, otherwise it holds. Result and zero hold their values.
- lock_owner = one-hot of the current LOCKEDN state, 0 in UNLOCKED.
- Outputs depend only on current state, inputs and registers. There are no internal operand buffers.

## Timing
- Reset (async assert, sync to clk on deassert) sets: rspN_valid=0, rspN_result=0, rspN_zero=0, rr_ptr=0, lock_cnt=0, state UNLOCKED, lock_owner=0.
- Request-to-response latency is 1 cycle: rspN_valid rises the edge after reqN_valid&reqN_ready.
- Throughput per requester is 1 op/cycle when rspN_ready is held 1. A full slot with rspN_ready=0 back-pressures: reqN_ready=0.
- Simultaneous load and drain of one slot in the same cycle: the new value wins and rspN_valid stays 1.
- reqN_ready depends combinationally on reqN_valid and rspN_ready. Requesters must not make reqN_valid depend on reqN_ready.
- Payload is sampled only in the grant cycle. It may change after acceptance.
- The ALU result must settle within one clk period. The result is captured in the same cycle as the grant.
- Mid-operation reset discards both slots and any lock.

## Test plan
1. Single request: after reset, req0 {ctrl=0000, a=5, b=7}, rsp0_ready=1. Expect req0_ready=1 in cycle 0; next cycle rsp0_valid=1, result=12, zero=0.
2. Contention: both valid every cycle, lock=0, both rsp_ready=1. Expect grants 0,1,0,1…; req1 {0001, 9, 9} gives result=0, zero=1.
3. Back-pressure: rsp1_ready=0 with rsp1 full. Expect req1_ready=0 while req0 continues to be granted every cycle. Raising rsp1_ready drains slot 1 and re-grants req1 in the same cycle.
4. Lock sequence: req1 sends {1101 ROTL, a=32'h80000001, b=1, lock=1}, then {0100 XOR, lock=0}, with req0 valid throughout. Expect ROTL result 32'h00000003 and lock_owner=2'b10. Expect req0_ready=0 until the XOR is granted. Expect req0 to be granted the next cycle.
5. Forced release: req1 locks, then goes invalid, with req0 valid. Expect lock_owner=2'b10 for exactly LOCK_MAX(8) cycles, then UNLOCKED and req0 granted on the next cycle.
6. Reset mid-lock: assert rst_n=0 asynchronously while LOCKED1 with both slots full. Expect immediately rsp0_valid=rsp1_valid=0, results=0, lock_owner=0. After release, the first contended grant goes to req0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the integer pipeline
// (requester 0) and the crypto coprocessor (requester 1), with a bounded grant lock.
module alu_share_arbiter #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_lock,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_lock,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [1:0]        lock_owner
);

  localparam int CNT_W = $clog2(LOCK_MAX);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_e;

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               rsp0_valid_q, rsp0_valid_d;
  logic               rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]  rsp0_result_q, rsp0_result_d;
  logic [DATA_W-1:0]  rsp1_result_q, rsp1_result_d;
  logic               rsp0_zero_q, rsp0_zero_d;
  logic               rsp1_zero_q, rsp1_zero_d;

  logic elig0, elig1, grant0, grant1, lock_expired;

  assign elig0        = req0_valid & (~rsp0_valid_q | rsp0_ready);
  assign elig1        = req1_valid & (~rsp1_valid_q | rsp1_ready);
  assign lock_expired = (lock_cnt_q == CNT_W'(LOCK_MAX - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      rr_ptr_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (grant0) begin
          if (req0_lock) begin
            state_d    = LOCKED0;
            lock_cnt_d = '0;
          end else begin
            rr_ptr_d = 1'b1;
          end
        end else if (grant1) begin
          if (req1_lock) begin
            state_d    = LOCKED1;
            lock_cnt_d = '0;
          end else begin
            rr_ptr_d = 1'b0;
          end
        end
      end
      LOCKED0: begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        // Forced release wins over a same-cycle lock request; that grant still lands.
        if (lock_expired || (grant0 && !req0_lock)) begin
          state_d    = UNLOCKED;
          rr_ptr_d   = 1'b1;
          lock_cnt_d = '0;
        end
      end
      LOCKED1: begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (lock_expired || (grant1 && !req1_lock)) begin
          state_d    = UNLOCKED;
          rr_ptr_d   = 1'b0;
          lock_cnt_d = '0;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    lock_owner = 2'b00;
    case (state_q)
      LOCKED0: begin
        grant0     = elig0;
        lock_owner = 2'b01;
      end
      LOCKED1: begin
        grant1     = elig1;
        lock_owner = 2'b10;
      end
      default: begin
        if (elig0 && elig1) begin
          grant0 = ~rr_ptr_q;
          grant1 = rr_ptr_q;
        end else begin
          grant0 = elig0;
          grant1 = elig1;
        end
      end
    endcase

    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    if (grant0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_ctrl;
    end else if (grant1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // A load in the same cycle as a drain keeps the slot full with the new value.
  always_comb begin
    rsp0_valid_d  = grant0 ? 1'b1 : (rsp0_valid_q & ~rsp0_ready);
    rsp0_result_d = grant0 ? alu_result : rsp0_result_q;
    rsp0_zero_d   = grant0 ? alu_zero : rsp0_zero_q;
    rsp1_valid_d  = grant1 ? 1'b1 : (rsp1_valid_q & ~rsp1_ready);
    rsp1_result_d = grant1 ? alu_result : rsp1_result_q;
    rsp1_zero_d   = grant1 ? alu_zero : rsp1_zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the arbitration and lock rules.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_lock;
  logic [CW-1:0] req0_ctrl;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_lock;
  logic [CW-1:0] req1_ctrl;
  logic [DW-1:0] req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp0_zero;
  logic [DW-1:0] rsp0_result;
  logic          rsp1_valid, rsp1_ready, rsp1_zero;
  logic [DW-1:0] rsp1_result;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero;
  logic [1:0]    lock_owner;

  alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_lock(req1_lock),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .lock_owner(lock_owner)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_fn(input logic [CW-1:0] c,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (c)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b1101: return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      default: return '0;
    endcase
  endfunction

  // External ALU stand-in.
  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner -1 means nobody holds the lock.
  int          m_owner, m_rr, m_cnt;
  bit          m_full[2];
  logic [DW-1:0] m_res[2];
  bit          m_zero[2];
  int          last_grant;
  logic        obs_r0, obs_r1;
  logic [1:0]  obs_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_cnt = 0;
    for (int n = 0; n < 2; n++) begin
      m_full[n] = 1'b0; m_res[n] = '0; m_zero[n] = 1'b0;
    end
  endtask

  // Called just after a rising edge with inputs already set; checks the
  // combinational outputs, lets one edge pass, then checks the slots.
  task automatic cycle();
    bit e0, e1, lk[2], rdy[2];
    int g;
    logic [DW-1:0] res[2];
    logic [DW-1:0] ea, eb;
    logic [CW-1:0] ec;
    #3;
    rdy[0] = rsp0_ready; rdy[1] = rsp1_ready;
    lk[0] = req0_lock;   lk[1] = req1_lock;
    e0 = req0_valid && (!m_full[0] || rdy[0]);
    e1 = req1_valid && (!m_full[1] || rdy[1]);
    g = -1;
    if (m_owner == 0)      g = e0 ? 0 : -1;
    else if (m_owner == 1) g = e1 ? 1 : -1;
    else if (e0 && e1)     g = m_rr;
    else if (e0)           g = 0;
    else if (e1)           g = 1;
    res[0] = alu_fn(req0_ctrl, req0_a, req0_b);
    res[1] = alu_fn(req1_ctrl, req1_a, req1_b);
    ea = (g == 0) ? req0_a : (g == 1) ? req1_a : '0;
    eb = (g == 0) ? req0_b : (g == 1) ? req1_b : '0;
    ec = (g == 0) ? req0_ctrl : (g == 1) ? req1_ctrl : '0;
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_lo = lock_owner;
    check("req0_ready", req0_ready, (g == 0));
    check("req1_ready", req1_ready, (g == 1));
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_ctrl", alu_ctrl, ec);
    check("lock_owner", lock_owner, (m_owner < 0) ? 0 : (1 << m_owner));
    last_grant = g;

    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (g == n) begin
        m_full[n] = 1'b1; m_res[n] = res[n]; m_zero[n] = (res[n] == '0);
      end else if (rdy[n]) begin
        m_full[n] = 1'b0;
      end
    end
    if (m_owner < 0) begin
      if (g >= 0) begin
        if (lk[g]) begin m_owner = g; m_cnt = 0; end
        else m_rr = 1 - g;
      end
    end else if (m_cnt == LM - 1 || (g == m_owner && !lk[m_owner])) begin
      m_rr = 1 - m_owner; m_owner = -1; m_cnt = 0;
    end else begin
      m_cnt++;
    end
    check("rsp0_valid", rsp0_valid, m_full[0]);
    check("rsp0_result", rsp0_result, m_res[0]);
    check("rsp0_zero", rsp0_zero, m_zero[0]);
    check("rsp1_valid", rsp1_valid, m_full[1]);
    check("rsp1_result", rsp1_result, m_res[1]);
    check("rsp1_zero", rsp1_zero, m_zero[1]);
  endtask

  task automatic set_req(input int n, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic l);
    if (n == 0) begin
      req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; req0_lock = l;
    end else begin
      req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; req1_lock = l;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CW-1:0] ops [6];
    int prev_g, lock_cycles, first_r0;
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
    ops[3] = 4'b0011; ops[4] = 4'b0100; ops[5] = 4'b1101;

    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_rsp0_valid", rsp0_valid, 0);
    check("reset_rsp1_valid", rsp1_valid, 0);
    check("reset_rsp0_result", rsp0_result, 0);
    check("reset_lock_owner", lock_owner, 0);

    // Single request: 5 + 7.
    set_req(0, 1, 4'b0000, 32'd5, 32'd7, 0);
    rsp0_ready = 1'b1;
    cycle();
    check("t1_result", rsp0_result, 32'd12);
    check("t1_zero", rsp0_zero, 0);
    check("t1_valid", rsp0_valid, 1);

    // Contention: alternate grants.
    set_req(1, 1, 4'b0001, 32'd9, 32'd9, 0);
    rsp1_ready = 1'b1;
    cycle();
    prev_g = last_grant;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t2_alternate", (last_grant != prev_g), 1);
      prev_g = last_grant;
    end
    check("t2_sub_result", rsp1_result, 32'd0);
    check("t2_sub_zero", rsp1_zero, 1);

    // Back-pressure on slot 1.
    rsp1_ready = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 4'b0010, $urandom, $urandom, 0);
      cycle();
      check("t3_req1_blocked", obs_r1, 0);
      check("t3_req0_granted", obs_r0, 1);
    end
    rsp1_ready = 1'b1;
    cycle();
    check("t3_req1_regrant", obs_r1, 1);

    // Lock sequence: ROTL (locked) then XOR releases.
    req1_valid = 1'b0;
    cycle();
    set_req(1, 1, 4'b1101, 32'h8000_0001, 32'd1, 1);
    cycle();
    check("t4_rotl_result", rsp1_result, 32'h0000_0003);
    check("t4_lock_owner", lock_owner, 2'b10);
    req1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("t4_req0_held", obs_r0, 0);
    end
    set_req(1, 1, 4'b0100, 32'h0000_00ff, 32'h0000_0f0f, 0);
    cycle();
    check("t4_xor_granted", obs_r1, 1);
    check("t4_req0_held_xor", obs_r0, 0);
    check("t4_xor_result", rsp1_result, 32'h0000_0ff0);
    req1_valid = 1'b0;
    cycle();
    check("t4_req0_after", obs_r0, 1);

    // Forced release after LOCK_MAX cycles.
    set_req(1, 1, 4'b0000, 32'd1, 32'd2, 1);
    cycle();
    check("t5_lock_grant", obs_r1, 1);
    set_req(1, 0, 0, 0, 0, 0);
    lock_cycles = 0;
    first_r0 = -1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (obs_lo == 2'b10) lock_cycles++;
      if (obs_r0 && first_r0 < 0) first_r0 = i;
    end
    check("t5_lock_cycles", lock_cycles, LM);
    check("t5_req0_first_grant", first_r0, LM);

    // Reset while locked with both slots full.
    req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cycle();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req(1, 1, 4'b0011, 32'h1234, 32'h10, 1);
    cycle();
    check("t6_pre_lock", lock_owner, 2'b10);
    check("t6_pre_full0", rsp0_valid, 1);
    check("t6_pre_full1", rsp1_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid0", rsp0_valid, 0);
    check("t6_rst_valid1", rsp1_valid, 0);
    check("t6_rst_result0", rsp0_result, 0);
    check("t6_rst_result1", rsp1_result, 0);
    check("t6_rst_lock", lock_owner, 0);
    model_reset();
    set_req(0, 1, 4'b0000, 32'd3, 32'd4, 0);
    set_req(1, 1, 4'b0000, 32'd6, 32'd8, 0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_first_grant0", req0_ready, 1);
    check("t6_first_grant1", req1_ready, 0);
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        logic [DW-1:0] a;
        a = $urandom;
        set_req(n, ($urandom_range(0, 3) != 0), ops[$urandom_range(0, 5)], a,
                ($urandom_range(0, 4) == 0) ? a : DW'($urandom),
                ($urandom_range(0, 3) == 0));
      end
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
